cnn_layer_sequencer: RTL and testbench

Parametrised layer-level control FSM for the fused-block CNN accelerator. It sits between the host/config registers and the BRAM loaders, PE array and OFM writer. It sequences a whole convolution layer as one IFM load, then per output-channel tile: weight load, compute, store. Unlike the single-shot controller it handles ofm_c > TOTAL_PE by tiling, uses valid/grant memory handshakes, and returns to idle with a done pulse.

---
 rtl/cnn_layer_sequencer_if.sv | 27 ++
 rtl/cnn_layer_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_sequencer_if.sv
// Memory and compute handshake bundle between the layer sequencer and its
// IFM/weight loaders, PE array and OFM writer.
interface cnn_layer_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              ifm_req;
  logic [ADDR_W-1:0] ifm_addr;
  logic              ifm_gnt;
  logic              wgt_req;
  logic [ADDR_W-1:0] wgt_addr;
  logic              wgt_gnt;
  logic              ofm_req;
  logic [ADDR_W-1:0] ofm_addr;
  logic              ofm_gnt;
  logic              cal_start;
  logic              cal_done;

  modport master (
    output ifm_req, ifm_addr, wgt_req, wgt_addr, ofm_req, ofm_addr, cal_start,
    input  ifm_gnt, wgt_gnt, ofm_gnt, cal_done
  );

  modport slave (
    input  ifm_req, ifm_addr, wgt_req, wgt_addr, ofm_req, ofm_addr, cal_start,
    output ifm_gnt, wgt_gnt, ofm_gnt, cal_done
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Layer-level control FSM: one IFM load, then per output-channel tile a
// weight load, compute and store, with contiguous weight/OFM addressing.
module cnn_layer_sequencer #(
  parameter int TOTAL_PE       = 16,
  parameter int DIM_W          = 8,
  parameter int ADDR_W         = 32,
  parameter int BYTES_PER_BEAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        kernel_w,
  input  logic [DIM_W-1:0]  ifm_w,
  input  logic [DIM_W-1:0]  ifm_c,
  input  logic [DIM_W-1:0]  ofm_w,
  input  logic [DIM_W-1:0]  ofm_c,
  input  logic [1:0]        stride,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [ADDR_W-1:0] ofm_base,
  cnn_layer_sequencer_if.master mem,
  output logic [DIM_W-1:0]  tile_idx,
  output logic [DIM_W-1:0]  tile_ch,
  output logic [3:0]        cfg_kernel_w_o,
  output logic [DIM_W-1:0]  cfg_ifm_w_o,
  output logic [DIM_W-1:0]  cfg_ifm_c_o,
  output logic [DIM_W-1:0]  cfg_ofm_w_o,
  output logic [1:0]        cfg_stride_o,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_IFM = 3'd1,
    LD_WGT = 3'd2,
    CAL    = 3'd3,
    STORE  = 3'd4,
    NEXT   = 3'd5
  } state_t;

  localparam int                BEAT_SH    = $clog2(BYTES_PER_BEAT);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BYTES_PER_BEAT);
  localparam logic [ADDR_W-1:0] BEAT_RND   = ADDR_W'(BYTES_PER_BEAT - 1);
  localparam logic [DIM_W-1:0]  PE_CH      = DIM_W'(TOTAL_PE);

  function automatic logic [ADDR_W-1:0] to_beats(input logic [ADDR_W-1:0] bytes);
    return (bytes + BEAT_RND) >> BEAT_SH;
  endfunction

  function automatic logic [DIM_W-1:0] min_pe(input logic [DIM_W-1:0] ch);
    return (ch > PE_CH) ? PE_CH : ch;
  endfunction

  state_t            state_q, state_d;
  logic              ifm_req_q, ifm_req_d, wgt_req_q, wgt_req_d, ofm_req_q, ofm_req_d;
  logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d, wgt_addr_q, wgt_addr_d, ofm_addr_q, ofm_addr_d;
  logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              cal_start_q, cal_start_d, done_q, done_d, err_q, err_d;
  logic [DIM_W-1:0]  tile_idx_q, tile_idx_d, tile_ch_q, tile_ch_d, rem_ch_q, rem_ch_d;
  logic [3:0]        k_q, k_d;
  logic [DIM_W-1:0]  ifm_w_q, ifm_w_d, ifm_c_q, ifm_c_d, ofm_w_q, ofm_w_d;
  logic [1:0]        stride_q, stride_d;
  logic [ADDR_W-1:0] wgt_bytes_per_ch, ofm_bytes_per_ch;
  logic [DIM_W-1:0]  next_ch;

  // Per-channel byte footprints of one tile; scaled by tile_ch when a phase starts.
  assign wgt_bytes_per_ch = ADDR_W'(ifm_c_q) * ADDR_W'(k_q) * ADDR_W'(k_q);
  assign ofm_bytes_per_ch = ADDR_W'(ofm_w_q) * ADDR_W'(ofm_w_q);
  assign next_ch          = min_pe(rem_ch_q);

  always_comb begin
    state_d     = state_q;
    ifm_req_d   = ifm_req_q;
    wgt_req_d   = wgt_req_q;
    ofm_req_d   = ofm_req_q;
    ifm_addr_d  = ifm_addr_q;
    wgt_addr_d  = wgt_addr_q;
    ofm_addr_d  = ofm_addr_q;
    beat_cnt_d  = beat_cnt_q;
    tile_idx_d  = tile_idx_q;
    tile_ch_d   = tile_ch_q;
    rem_ch_d    = rem_ch_q;
    k_d         = k_q;
    ifm_w_d     = ifm_w_q;
    ifm_c_d     = ifm_c_q;
    ofm_w_d     = ofm_w_q;
    stride_d    = stride_q;
    cal_start_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_d        = kernel_w;
          ifm_w_d    = ifm_w;
          ifm_c_d    = ifm_c;
          ofm_w_d    = ofm_w;
          stride_d   = stride;
          ifm_addr_d = ifm_base;
          wgt_addr_d = wgt_base;
          ofm_addr_d = ofm_base;
          if (kernel_w == '0 || ifm_w == '0 || ifm_c == '0 || ofm_w == '0 || ofm_c == '0) begin
            err_d = 1'b1;
          end else begin
            state_d    = LD_IFM;
            tile_idx_d = '0;
            tile_ch_d  = min_pe(ofm_c);
            rem_ch_d   = ofm_c - min_pe(ofm_c);
            ifm_req_d  = 1'b1;
            beat_cnt_d = to_beats(ADDR_W'(ifm_w) * ADDR_W'(ifm_w) * ADDR_W'(ifm_c));
          end
        end
      end
      LD_IFM: begin
        if (ifm_req_q && mem.ifm_gnt) begin
          ifm_addr_d = ifm_addr_q + BEAT_BYTES;
          beat_cnt_d = beat_cnt_q - ADDR_W'(1);
          if (beat_cnt_q == ADDR_W'(1)) begin
            ifm_req_d  = 1'b0;
            wgt_req_d  = 1'b1;
            beat_cnt_d = to_beats(wgt_bytes_per_ch * ADDR_W'(tile_ch_q));
            state_d    = LD_WGT;
          end
        end
      end
      LD_WGT: begin
        if (wgt_req_q && mem.wgt_gnt) begin
          wgt_addr_d = wgt_addr_q + BEAT_BYTES;
          beat_cnt_d = beat_cnt_q - ADDR_W'(1);
          if (beat_cnt_q == ADDR_W'(1)) begin
            wgt_req_d   = 1'b0;
            cal_start_d = 1'b1;
            state_d     = CAL;
          end
        end
      end
      CAL: begin
        if (mem.cal_done) begin
          ofm_req_d  = 1'b1;
          beat_cnt_d = to_beats(ofm_bytes_per_ch * ADDR_W'(tile_ch_q));
          state_d    = STORE;
        end
      end
      STORE: begin
        if (ofm_req_q && mem.ofm_gnt) begin
          ofm_addr_d = ofm_addr_q + BEAT_BYTES;
          beat_cnt_d = beat_cnt_q - ADDR_W'(1);
          if (beat_cnt_q == ADDR_W'(1)) begin
            ofm_req_d = 1'b0;
            state_d   = NEXT;
          end
        end
      end
      NEXT: begin
        // Weight and OFM addresses are left where the previous tile ended.
        if (rem_ch_q != '0) begin
          tile_idx_d = tile_idx_q + DIM_W'(1);
          tile_ch_d  = next_ch;
          rem_ch_d   = rem_ch_q - next_ch;
          wgt_req_d  = 1'b1;
          beat_cnt_d = to_beats(wgt_bytes_per_ch * ADDR_W'(next_ch));
          state_d    = LD_WGT;
        end else begin
          done_d     = 1'b1;
          tile_idx_d = '0;
          tile_ch_d  = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over start and over any grant seen this cycle.
    if (abort) begin
      state_d     = IDLE;
      ifm_req_d   = 1'b0;
      wgt_req_d   = 1'b0;
      ofm_req_d   = 1'b0;
      ifm_addr_d  = '0;
      wgt_addr_d  = '0;
      ofm_addr_d  = '0;
      cal_start_d = 1'b0;
      beat_cnt_d  = '0;
      tile_idx_d  = '0;
      tile_ch_d   = '0;
      rem_ch_d    = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ifm_req_q   <= 1'b0;
      wgt_req_q   <= 1'b0;
      ofm_req_q   <= 1'b0;
      ifm_addr_q  <= '0;
      wgt_addr_q  <= '0;
      ofm_addr_q  <= '0;
      beat_cnt_q  <= '0;
      cal_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tile_idx_q  <= '0;
      tile_ch_q   <= '0;
      rem_ch_q    <= '0;
      k_q         <= '0;
      ifm_w_q     <= '0;
      ifm_c_q     <= '0;
      ofm_w_q     <= '0;
      stride_q    <= '0;
    end else begin
      state_q     <= state_d;
      ifm_req_q   <= ifm_req_d;
      wgt_req_q   <= wgt_req_d;
      ofm_req_q   <= ofm_req_d;
      ifm_addr_q  <= ifm_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      ofm_addr_q  <= ofm_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      cal_start_q <= cal_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tile_idx_q  <= tile_idx_d;
      tile_ch_q   <= tile_ch_d;
      rem_ch_q    <= rem_ch_d;
      k_q         <= k_d;
      ifm_w_q     <= ifm_w_d;
      ifm_c_q     <= ifm_c_d;
      ofm_w_q     <= ofm_w_d;
      stride_q    <= stride_d;
    end
  end

  assign mem.ifm_req   = ifm_req_q;
  assign mem.ifm_addr  = ifm_addr_q;
  assign mem.wgt_req   = wgt_req_q;
  assign mem.wgt_addr  = wgt_addr_q;
  assign mem.ofm_req   = ofm_req_q;
  assign mem.ofm_addr  = ofm_addr_q;
  assign mem.cal_start = cal_start_q;

  assign tile_idx       = tile_idx_q;
  assign tile_ch        = tile_ch_q;
  assign cfg_kernel_w_o = k_q;
  assign cfg_ifm_w_o    = ifm_w_q;
  assign cfg_ifm_c_o    = ifm_c_q;
  assign cfg_ofm_w_o    = ofm_w_q;
  assign cfg_stride_o   = stride_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: a tile-level reference model queues
// the expected beat/pulse stream and a negedge monitor pops and compares it.
module tb_cnn_layer_sequencer;

  localparam int DIM_W  = 8;
  localparam int ADDR_W = 32;
  localparam int PE     = 16;
  localparam int BPB    = 4;

  localparam int K_IFM = 1, K_WGT = 2, K_CAL = 3, K_OFM = 4, K_DONE = 5, K_ERR = 6;
  localparam logic [2:0] S_IDLE = 3'd0, S_LD_IFM = 3'd1, S_LD_WGT = 3'd2, S_CAL = 3'd3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          tile;
    int          ch;
  } ev_t;

  typedef struct {
    logic [3:0]  k;
    logic [7:0]  ifm_w, ifm_c, ofm_w, ofm_c;
    logic [1:0]  stride;
    logic [31:0] ifm_base, wgt_base, ofm_base;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [3:0]        kernel_w;
  logic [DIM_W-1:0]  ifm_w, ifm_c, ofm_w, ofm_c;
  logic [1:0]        stride;
  logic [ADDR_W-1:0] ifm_base, wgt_base, ofm_base;
  logic [DIM_W-1:0]  tile_idx, tile_ch, cfg_ifm_w_o, cfg_ifm_c_o, cfg_ofm_w_o;
  logic [3:0]        cfg_kernel_w_o;
  logic [1:0]        cfg_stride_o;
  logic              busy, done, err;
  logic [2:0]        state_o;

  cnn_layer_sequencer_if #(.ADDR_W(ADDR_W)) mem ();

  cnn_layer_sequencer #(
    .TOTAL_PE(PE), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .BYTES_PER_BEAT(BPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .kernel_w(kernel_w), .ifm_w(ifm_w), .ifm_c(ifm_c), .ofm_w(ofm_w), .ofm_c(ofm_c),
    .stride(stride), .ifm_base(ifm_base), .wgt_base(wgt_base), .ofm_base(ofm_base),
    .mem(mem), .tile_idx(tile_idx), .tile_ch(tile_ch),
    .cfg_kernel_w_o(cfg_kernel_w_o), .cfg_ifm_w_o(cfg_ifm_w_o), .cfg_ifm_c_o(cfg_ifm_c_o),
    .cfg_ofm_w_o(cfg_ofm_w_o), .cfg_stride_o(cfg_stride_o),
    .busy(busy), .done(done), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails = 0;
  int  gnt_mode = 0;
  int  cal_mode = 0;
  int  ld_ifm_cycles, busy_cycles;

  function automatic string kind_name(input int k);
    case (k)
      K_IFM:   return "ifm_beat";
      K_WGT:   return "wgt_beat";
      K_CAL:   return "cal_start";
      K_OFM:   return "ofm_beat";
      K_DONE:  return "done";
      default: return "err";
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] addr, input int tile, input int ch);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.tile = tile;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  // Reference: the layer as a list of beats per phase, tiles of up to PE channels.
  task automatic build_model(input cfg_t c);
    int n, rem, ch, t;
    logic [31:0] a;
    if (c.k == 0 || c.ifm_w == 0 || c.ifm_c == 0 || c.ofm_w == 0 || c.ofm_c == 0) begin
      push_ev(K_ERR, 0, 0, 0);
      return;
    end
    n = (int'(c.ifm_w) * int'(c.ifm_w) * int'(c.ifm_c) + BPB - 1) / BPB;
    for (int i = 0; i < n; i++) push_ev(K_IFM, c.ifm_base + 32'(i * BPB), 0, 0);
    rem = int'(c.ofm_c);
    t = 0;
    a = c.wgt_base;
    while (rem > 0) begin
      ch = (rem > PE) ? PE : rem;
      n = (int'(c.ifm_c) * int'(c.k) * int'(c.k) * ch + BPB - 1) / BPB;
      for (int i = 0; i < n; i++) begin
        push_ev(K_WGT, a, t, ch);
        a = a + 32'(BPB);
      end
      push_ev(K_CAL, 0, 0, 0);
      rem = rem - ch;
      t++;
    end
    // Store beats are interleaved per tile, so rebuild with OFM slotted after each CAL.
    begin
      ev_t tmp[$];
      logic [31:0] oa;
      int tt;
      oa = c.ofm_base;
      tt = 0;
      rem = int'(c.ofm_c);
      while (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        tmp.push_back(e);
        if (e.kind == K_CAL) begin
          ch = (rem > PE) ? PE : rem;
          n = (int'(c.ofm_w) * int'(c.ofm_w) * ch + BPB - 1) / BPB;
          for (int i = 0; i < n; i++) begin
            ev_t o;
            o.kind = K_OFM; o.addr = oa; o.tile = tt; o.ch = ch;
            tmp.push_back(o);
            oa = oa + 32'(BPB);
          end
          rem = rem - ch;
          tt++;
        end
      end
      exp_q = tmp;
    end
    push_ev(K_DONE, 0, 0, 0);
  endtask

  task automatic observe(input int kind, input logic [31:0] addr, input int tile, input int ch);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL unexpected_%s: actual event at addr 0x%0h, required none", kind_name(kind), addr);
    end else begin
      e = exp_q.pop_front();
      check_output(kind_name(e.kind), 64'({8'(kind), addr, 8'(tile), 8'(ch)}),
                   64'({8'(e.kind), e.addr, 8'(e.tile), 8'(e.ch)}));
    end
  endtask

  // Grant and cal_done drivers, updated just after each rising edge.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    mem.ifm_gnt = 1'b0; mem.wgt_gnt = 1'b0; mem.ofm_gnt = 1'b0; mem.cal_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gnt_mode == 0) begin
        mem.ifm_gnt = 1'b1; mem.wgt_gnt = 1'b1; mem.ofm_gnt = 1'b1;
      end else if (gnt_mode == 1) begin
        mem.ifm_gnt = ($urandom_range(0, 2) != 0);
        mem.wgt_gnt = ($urandom_range(0, 2) != 0);
        mem.ofm_gnt = ($urandom_range(0, 2) != 0);
      end else begin
        mem.wgt_gnt = 1'b1; mem.ofm_gnt = 1'b1;
        if (mem.ifm_req) begin
          mem.ifm_gnt = (hold_cnt == 3);
          hold_cnt = (hold_cnt == 3) ? 0 : hold_cnt + 1;
        end else begin
          mem.ifm_gnt = 1'b0;
          hold_cnt = 0;
        end
      end
      mem.cal_done = (cal_mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: pops one expected event per observed beat/pulse and checks req/addr holds.
  initial begin
    logic p_ok, p_ir, p_ig, p_wr, p_wg, p_or, p_og;
    logic [31:0] p_ia, p_wa, p_oa;
    p_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ok = 1'b0;
      end else begin
        if (!abort) begin
          if (mem.ifm_req && mem.ifm_gnt) observe(K_IFM, mem.ifm_addr, 0, 0);
          if (mem.wgt_req && mem.wgt_gnt) observe(K_WGT, mem.wgt_addr, int'(tile_idx), int'(tile_ch));
          if (mem.cal_start)              observe(K_CAL, 0, 0, 0);
          if (mem.ofm_req && mem.ofm_gnt) observe(K_OFM, mem.ofm_addr, int'(tile_idx), int'(tile_ch));
          if (done)                       observe(K_DONE, 0, 0, 0);
          if (err)                        observe(K_ERR, 0, 0, 0);
        end
        if (p_ok && p_ir && !p_ig) check_output("ifm_hold", 64'({mem.ifm_req, mem.ifm_addr}), 64'({1'b1, p_ia}));
        if (p_ok && p_wr && !p_wg) check_output("wgt_hold", 64'({mem.wgt_req, mem.wgt_addr}), 64'({1'b1, p_wa}));
        if (p_ok && p_or && !p_og) check_output("ofm_hold", 64'({mem.ofm_req, mem.ofm_addr}), 64'({1'b1, p_oa}));
        p_ir = mem.ifm_req; p_ig = mem.ifm_gnt; p_ia = mem.ifm_addr;
        p_wr = mem.wgt_req; p_wg = mem.wgt_gnt; p_wa = mem.wgt_addr;
        p_or = mem.ofm_req; p_og = mem.ofm_gnt; p_oa = mem.ofm_addr;
        p_ok = !abort;
      end
    end
  end

  task automatic scramble_cfg();
    kernel_w = 4'($urandom);
    ifm_w    = 8'($urandom);
    ifm_c    = 8'($urandom);
    ofm_w    = 8'($urandom);
    ofm_c    = 8'($urandom);
    stride   = 2'($urandom);
  endtask

  task automatic apply_stimulus(input cfg_t c);
    kernel_w = c.k; ifm_w = c.ifm_w; ifm_c = c.ifm_c; ofm_w = c.ofm_w; ofm_c = c.ofm_c;
    stride = c.stride; ifm_base = c.ifm_base; wgt_base = c.wgt_base; ofm_base = c.ofm_base;
    build_model(c);
    start = 1'b1;
  endtask

  task automatic run_layer(input cfg_t c, input bit start_in_cal);
    bit poked;
    poked = 1'b0;
    ld_ifm_cycles = 0;
    busy_cycles = 0;
    apply_stimulus(c);
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_cfg();
    check_output("cfg_latch",
                 64'({cfg_kernel_w_o, cfg_ifm_w_o, cfg_ifm_c_o, cfg_ofm_w_o, cfg_stride_o}),
                 64'({c.k, c.ifm_w, c.ifm_c, c.ofm_w, c.stride}));
    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) begin
      if (state_o == S_LD_IFM) ld_ifm_cycles++;
      if (busy || mem.ifm_req || mem.wgt_req || mem.ofm_req) busy_cycles++;
      if (start_in_cal && !poked && state_o == S_CAL) begin
        start = 1'b1;
        ofm_c = '0;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check_output("drain_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check_output("idle_after_layer", 64'({busy, state_o}), 64'd0);
    if (start_in_cal) check_output("start_in_cal_issued", 64'(poked), 64'd1);
  endtask

  function automatic cfg_t plan_cfg();
    cfg_t c;
    c.k = 4'd3; c.ifm_w = 8'd4; c.ifm_c = 8'd4; c.ofm_w = 8'd2; c.ofm_c = 8'd20; c.stride = 2'd1;
    c.ifm_base = 32'h0; c.wgt_base = 32'h1000; c.ofm_base = 32'h2000;
    return c;
  endfunction

  initial begin
    cfg_t c;
    int   n_wgt;
    start = 1'b0; abort = 1'b0;
    scramble_cfg();
    ifm_base = '0; wgt_base = '0; ofm_base = '0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_state",
                 64'({state_o, busy, done, err, mem.ifm_req, mem.wgt_req, mem.ofm_req, mem.cal_start, tile_idx, tile_ch}),
                 64'd0);
    check_output("reset_addr", 64'({mem.ifm_addr, mem.wgt_addr}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] two-tile layer, grants always high");
    gnt_mode = 0; cal_mode = 0;
    run_layer(plan_cfg(), 1'b0);

    $display("[TB] same layer, IFM grant low three cycles per beat");
    gnt_mode = 2;
    run_layer(plan_cfg(), 1'b0);
    check_output("ld_ifm_cycles", 64'(ld_ifm_cycles), 64'd64);

    $display("[TB] single tile, start during CAL");
    gnt_mode = 1; cal_mode = 1;
    c = plan_cfg(); c.ofm_c = 8'd16;
    run_layer(c, 1'b1);

    $display("[TB] 9-byte IFM rounds up to three beats");
    c = plan_cfg(); c.ifm_w = 8'd3; c.ifm_c = 8'd1; c.ifm_base = 32'h300;
    run_layer(c, 1'b0);

    $display("[TB] zero ofm_c raises err");
    gnt_mode = 0;
    c = plan_cfg(); c.ofm_c = 8'd0;
    run_layer(c, 1'b0);
    check_output("err_no_busy", 64'(busy_cycles), 64'd0);

    $display("[TB] abort during weight load");
    gnt_mode = 0; cal_mode = 0;
    apply_stimulus(plan_cfg());
    @(posedge clk);
    #1 start = 1'b0;
    n_wgt = 0;
    for (int i = 0; i < 500 && n_wgt < 5; i++) begin
      if (state_o == S_LD_WGT) n_wgt++;
      @(posedge clk);
      #1;
    end
    check_output("abort_setup", 64'({state_o, mem.wgt_req, mem.wgt_gnt}), 64'({S_LD_WGT, 1'b1, 1'b1}));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    check_output("abort_idle",
                 64'({state_o, busy, mem.ifm_req, mem.wgt_req, mem.ofm_req, mem.cal_start, done, tile_idx}),
                 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_output("abort_stays_idle", 64'({state_o, busy}), 64'd0);
    c = plan_cfg(); c.ifm_base = 32'h5000;
    run_layer(c, 1'b0);

    $display("[TB] async reset mid-transfer");
    gnt_mode = 1;
    apply_stimulus(plan_cfg());
    repeat (4) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 64'({state_o, busy, mem.ifm_req, mem.wgt_req, mem.ifm_addr}), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_layer(plan_cfg(), 1'b0);

    $display("[TB] ofm_c=255, sixteen tiles");
    gnt_mode = 0;
    c.k = 4'd1; c.ifm_w = 8'd1; c.ifm_c = 8'd1; c.ofm_w = 8'd1; c.ofm_c = 8'd255; c.stride = 2'd2;
    c.ifm_base = 32'h10; c.wgt_base = 32'h2000; c.ofm_base = 32'h3000;
    run_layer(c, 1'b0);

    $display("[TB] randomized layers");
    gnt_mode = 1; cal_mode = 1;
    for (int r = 0; r < 10; r++) begin
      c.k = 4'($urandom_range(1, 3));
      c.ifm_w = 8'($urandom_range(1, 5));
      c.ifm_c = 8'($urandom_range(1, 4));
      c.ofm_w = 8'($urandom_range(1, 4));
      c.ofm_c = 8'($urandom_range(1, 40));
      c.stride = 2'($urandom);
      c.ifm_base = $urandom; c.wgt_base = $urandom; c.ofm_base = $urandom;
      run_layer(c, 1'b0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
